// File: rtl/mouse_click_decoder.sv
// Debounces the raw mouse left button and emits exactly one click event per press,
// carrying the cursor position and the goal zone (3 cols x 2 rows) it hit.
module mouse_click_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 65000,
  parameter int unsigned GOAL_X0         = 192,
  parameter int unsigned GOAL_Y0         = 192,
  parameter int unsigned GOAL_COL_W      = 200,
  parameter int unsigned GOAL_ROW_H      = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        click_ready,
  output logic        click_valid,
  output logic [11:0] click_x,
  output logic [11:0] click_y,
  output logic [2:0]  click_zone,
  output logic        click_in_goal,
  output logic [7:0]  click_count,
  output logic        busy
);

  localparam int unsigned CNT_W = 17;
  localparam int unsigned CMP_W = 13;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Column/row boundaries expressed as absolute coordinates so no subtraction is needed
  localparam logic [CMP_W-1:0] X_LO = CMP_W'(GOAL_X0);
  localparam logic [CMP_W-1:0] X_C1 = CMP_W'(GOAL_X0 + GOAL_COL_W);
  localparam logic [CMP_W-1:0] X_C2 = CMP_W'(GOAL_X0 + 2 * GOAL_COL_W);
  localparam logic [CMP_W-1:0] X_HI = CMP_W'(GOAL_X0 + 3 * GOAL_COL_W);
  localparam logic [CMP_W-1:0] Y_LO = CMP_W'(GOAL_Y0);
  localparam logic [CMP_W-1:0] Y_R1 = CMP_W'(GOAL_Y0 + GOAL_ROW_H);
  localparam logic [CMP_W-1:0] Y_HI = CMP_W'(GOAL_Y0 + 2 * GOAL_ROW_H);

  localparam logic [2:0] ZONE_OUTSIDE = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ARMING,
    CAPTURE,
    OFFER,
    RELEASE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             left_meta, left_s;

  logic             valid_d;
  logic [11:0]      x_d, y_d;
  logic [2:0]       zone_d;
  logic             in_goal_d;
  logic [7:0]       count_d;
  logic             busy_d;

  logic [CMP_W-1:0] x_ext_c, y_ext_c;
  logic             in_goal_c;
  logic [1:0]       col_c;
  logic             row_c;
  logic [2:0]       zone_c;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk) begin
    if (!rst) begin
      left_meta <= 1'b0;
      left_s    <= 1'b0;
    end else begin
      left_meta <= left;
      left_s    <= left_meta;
    end
  end

  // Goal-zone classification of the current cursor position, comparators only
  always_comb begin
    x_ext_c   = {1'b0, xpos};
    y_ext_c   = {1'b0, ypos};
    in_goal_c = (x_ext_c >= X_LO) && (x_ext_c < X_HI) &&
                (y_ext_c >= Y_LO) && (y_ext_c < Y_HI);
    col_c     = 2'd2;
    if (x_ext_c < X_C1) begin
      col_c = 2'd0;
    end else if (x_ext_c < X_C2) begin
      col_c = 2'd1;
    end
    row_c  = (y_ext_c >= Y_R1);
    zone_c = ZONE_OUTSIDE;
    if (in_goal_c) begin
      zone_c = row_c ? (3'd3 + {1'b0, col_c}) : {1'b0, col_c};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    valid_d   = click_valid;
    x_d       = click_x;
    y_d       = click_y;
    zone_d    = click_zone;
    in_goal_d = click_in_goal;
    count_d   = click_count;

    unique case (state)
      IDLE: begin
        if (left_s) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!left_s) begin
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        x_d       = xpos;
        y_d       = ypos;
        zone_d    = zone_c;
        in_goal_d = in_goal_c;
        valid_d   = 1'b1;
        state_d   = OFFER;
      end
      OFFER: begin
        if (click_valid && click_ready) begin
          valid_d = 1'b0;
          count_d = click_count + 8'd1;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (left_s) begin
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers; reset parks in RELEASE so a held button is ignored
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RELEASE;
      cnt           <= '0;
      click_valid   <= 1'b0;
      click_x       <= '0;
      click_y       <= '0;
      click_zone    <= ZONE_OUTSIDE;
      click_in_goal <= 1'b0;
      click_count   <= '0;
      busy          <= 1'b1;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      click_valid   <= valid_d;
      click_x       <= x_d;
      click_y       <= y_d;
      click_zone    <= zone_d;
      click_in_goal <= in_goal_d;
      click_count   <= count_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_mouse_click_decoder.sv
// Directed bench for mouse_click_decoder with a short debounce window.
module tb_mouse_click_decoder;

  logic        clk;
  logic        rst;
  logic        left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        click_ready;
  logic        click_valid;
  logic [11:0] click_x;
  logic [11:0] click_y;
  logic [2:0]  click_zone;
  logic        click_in_goal;
  logic [7:0]  click_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_count = 8'd0;

  mouse_click_decoder #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .left         (left),
    .xpos         (xpos),
    .ypos         (ypos),
    .click_ready  (click_ready),
    .click_valid  (click_valid),
    .click_x      (click_x),
    .click_y      (click_y),
    .click_zone   (click_zone),
    .click_in_goal(click_in_goal),
    .click_count  (click_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    exp_count = 8'd0;
  endtask

  // Release the button and let the release debounce finish
  task automatic release_and_settle(input string name);
    left = 1'b0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle busy: got %b expected 0", name, busy);
    end
  endtask

  // Press at (x,y) with ready high; expect one event with the given zone
  task automatic do_click(input logic [11:0] x, input logic [11:0] y,
                          input logic [2:0] zone, input logic in_goal,
                          input string name);
    int n;
    xpos = x;
    ypos = y;
    click_ready = 1'b1;
    left = 1'b1;
    n = 0;
    while (click_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (click_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid timeout: got %b expected 1", name, click_valid);
    end else begin
      checks++;
      if (click_x !== x || click_y !== y) begin
        errors++;
        $display("FAIL %s coords: got (%0d,%0d) expected (%0d,%0d)", name, click_x, click_y, x, y);
      end
      checks++;
      if (click_zone !== zone || click_in_goal !== in_goal) begin
        errors++;
        $display("FAIL %s zone: got %0d/%b expected %0d/%b", name, click_zone, click_in_goal, zone, in_goal);
      end
      tick();
      exp_count = exp_count + 8'd1;
      checks++;
      if (click_valid !== 1'b0 || click_count !== exp_count) begin
        errors++;
        $display("FAIL %s transfer: got valid=%b count=%0d expected valid=0 count=%0d",
                 name, click_valid, click_count, exp_count);
      end
    end
    release_and_settle(name);
  endtask

  task automatic test_reset();
    left = 1'b0;
    xpos = 12'd0;
    ypos = 12'd0;
    click_ready = 1'b1;
    apply_reset();
    checks++;
    if (click_valid !== 1'b0 || click_x !== 12'd0 || click_y !== 12'd0 ||
        click_zone !== 3'd7 || click_in_goal !== 1'b0 || click_count !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset values: got v=%b x=%0d y=%0d z=%0d g=%b c=%0d b=%b expected 0 0 0 7 0 0 1",
               click_valid, click_x, click_y, click_zone, click_in_goal, click_count, busy);
    end
    // Release debounce after reset: IDLE reached on the fourth edge
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset release early: got busy=%b expected 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset release done: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_latency();
    xpos = 12'd300;
    ypos = 12'd250;
    click_ready = 1'b1;
    left = 1'b1;
    repeat (7) tick();
    checks++;
    if (click_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency edge7: got valid=%b expected 0", click_valid);
    end
    tick();
    checks++;
    if (click_valid !== 1'b1 || click_x !== 12'd300 || click_y !== 12'd250 ||
        click_zone !== 3'd0 || click_in_goal !== 1'b1) begin
      errors++;
      $display("FAIL latency edge8: got v=%b x=%0d y=%0d z=%0d g=%b expected 1 300 250 0 1",
               click_valid, click_x, click_y, click_zone, click_in_goal);
    end
    tick();
    exp_count = 8'd1;
    checks++;
    if (click_valid !== 1'b0 || click_count !== 8'd1) begin
      errors++;
      $display("FAIL latency transfer: got valid=%b count=%0d expected 0 1", click_valid, click_count);
    end
    release_and_settle("latency");
  endtask

  task automatic test_zones();
    do_click(12'd700, 12'd450, 3'd5, 1'b1, "zone5");
    do_click(12'd100, 12'd100, 3'd7, 1'b0, "outside");
    do_click(12'd792, 12'd192, 3'd7, 1'b0, "right_edge");
    do_click(12'd791, 12'd351, 3'd2, 1'b1, "corner_in");
    do_click(12'd392, 12'd352, 3'd4, 1'b1, "col1_row1");
  endtask

  // Short presses must never produce an event
  task automatic test_bounce();
    bit seen;
    for (int len = 3; len <= 4; len++) begin
      seen = 1'b0;
      left = 1'b1;
      repeat (len) begin
        tick();
        if (click_valid === 1'b1) seen = 1'b1;
      end
      left = 1'b0;
      repeat (12) begin
        tick();
        if (click_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen || click_count !== exp_count || busy !== 1'b0) begin
        errors++;
        $display("FAIL bounce len %0d: got seen=%b count=%0d busy=%b expected 0 %0d 0",
                 len, seen, click_count, exp_count, busy);
      end
    end
  endtask

  // Consumer stalls while cursor moves and button releases
  task automatic test_backpressure();
    int n;
    bit unstable;
    xpos = 12'd450;
    ypos = 12'd300;
    click_ready = 1'b0;
    left = 1'b1;
    n = 0;
    while (click_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (click_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall valid timeout: got %b expected 1", click_valid);
    end
    left = 1'b0;
    unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      xpos = 12'(10 + 37 * i);
      ypos = 12'(700 - 41 * i);
      tick();
      if (click_valid !== 1'b1 || click_x !== 12'd450 || click_y !== 12'd300 ||
          click_zone !== 3'd1 || click_in_goal !== 1'b1 || click_count !== exp_count)
        unstable = 1'b1;
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL stall hold: got v=%b x=%0d y=%0d z=%0d c=%0d expected 1 450 300 1 %0d",
               click_valid, click_x, click_y, click_zone, click_count, exp_count);
    end
    click_ready = 1'b1;
    tick();
    exp_count = exp_count + 8'd1;
    checks++;
    if (click_valid !== 1'b0 || click_count !== exp_count) begin
      errors++;
      $display("FAIL stall transfer: got valid=%b count=%0d expected 0 %0d", click_valid, click_count, exp_count);
    end
    repeat (12) tick();
    checks++;
    if (click_count !== exp_count || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall single: got count=%0d busy=%b expected %0d 0", click_count, busy, exp_count);
    end
  endtask

  // Button held across reset stays silent until released and pressed again
  task automatic test_held_reset();
    bit seen;
    left = 1'b1;
    xpos = 12'd300;
    ypos = 12'd250;
    click_ready = 1'b1;
    apply_reset();
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (click_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || click_count !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL held reset: got seen=%b count=%0d busy=%b expected 0 0 1", seen, click_count, busy);
    end
    release_and_settle("held_release");
    do_click(12'd500, 12'd200, 3'd1, 1'b1, "after_held");
    checks++;
    if (click_count !== 8'd1) begin
      errors++;
      $display("FAIL after held count: got %0d expected 1", click_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    left = 1'b0;
    xpos = 12'd0;
    ypos = 12'd0;
    click_ready = 1'b0;
    tick();
    test_reset();
    test_latency();
    test_zones();
    test_bounce();
    test_backpressure();
    test_held_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
